// File: rtl/sha256_round_engine.sv
// SHA-256 compression core: loads one 512-bit block and a chaining value, then runs
// ROUNDS rounds at one round per clock and presents the final working variables a..h.
module sha256_round_engine #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic [255:0] h_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] work_out
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StRound = 1'b1;

    localparam logic [0:63][31:0] KRom = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [0:0]        state_q;
    logic [6:0]        t_q;
    logic [0:15][31:0] w_q;   // w_q[0] is always W[t] for the current round
    logic [0:7][31:0]  v_q;   // v_q[0] = a ... v_q[7] = h
    logic [255:0]      work_out_q;
    logic              busy_q;
    logic              done_q;

    logic [31:0]       t1;
    logic [31:0]       t2;
    logic [31:0]       w_new;
    logic [0:7][31:0]  v_next;
    logic              last_round;

    always_comb begin
        t1 = v_q[7] + big_sigma1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
             + KRom[t_q[5:0]] + w_q[0];
        t2 = big_sigma0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        // Word W[t+16] enters the window as W[t] leaves it.
        w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
        v_next = {t1 + t2, v_q[0], v_q[1], v_q[2], v_q[3] + t1, v_q[4], v_q[5], v_q[6]};
        last_round = (t_q == 7'(ROUNDS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            t_q        <= '0;
            w_q        <= '0;
            v_q        <= '0;
            work_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (state_q == StIdle) begin
            done_q <= 1'b0;
            if (start) begin
                w_q     <= block_in;
                v_q     <= h_in;
                t_q     <= '0;
                busy_q  <= 1'b1;
                state_q <= StRound;
            end
        end else begin
            v_q <= v_next;
            w_q <= {w_q[1:15], w_new};
            t_q <= t_q + 7'd1;
            if (last_round) begin
                work_out_q <= v_next;
                done_q     <= 1'b1;
                busy_q     <= 1'b0;
                state_q    <= StIdle;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign work_out = work_out_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Self-checking bench for sha256_round_engine: known-answer blocks, handshake timing,
// abort/ignore cases and random blocks checked against a behavioural SHA-256 model.
module tb_sha256_round_engine;

    localparam logic [255:0] HInit =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] AbcBlk = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EmptyBlk = {32'h80000000, 480'h0};
    localparam logic [255:0] AbcSum =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EmptySum =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [511:0] block_in = '0;
    logic [255:0] h_in = '0;
    logic         busy;
    logic         done;
    logic [255:0] work_out;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sha256_round_engine #(.ROUNDS(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .block_in (block_in),
        .h_in     (h_in),
        .busy     (busy),
        .done     (done),
        .work_out (work_out)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight FIPS 180-4 compression over a full 64-entry schedule; returns a..h.
    function automatic logic [255:0] ref_compress(input logic [511:0] blk,
                                                  input logic [255:0] hv);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, ch, mj, x1, x2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hv[255 - 32 * i -: 32];
        for (int t = 0; t < 64; t++) begin
            s1 = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
            ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
            x1 = v[7] + s1 + ch + KT[t] + w[t];
            s0 = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
            mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            x2 = s0 + mj;
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = v[i];
        return r;
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32 * i +: 32] = x[32 * i +: 32] + y[32 * i +: 32];
        return r;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32 * i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [255:0] rand_h();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32 * i +: 32] = $urandom();
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a block for one sampling edge, then scrambles the inputs.
    task automatic launch(input logic [511:0] blk, input logic [255:0] hv);
        block_in = blk;
        h_in     = hv;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        block_in = rand_block();
        h_in     = rand_h();
    endtask

    // Counts edges after the start edge until done; busy must hold until then.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = busy;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (done) begin
                lat = n;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [511:0] blk,
                                 input logic [255:0] hv);
        int lat;
        bit ok;
        launch(blk, hv);
        wait_done(lat, ok);
        check({tag, "_latency"}, 256'(lat), 256'd64);
        check({tag, "_busy"}, 256'(ok), 256'd1);
        check({tag, "_result"}, work_out, ref_compress(blk, hv));
        tick();
        check({tag, "_done_fall"}, 256'(done), 256'd0);
        check({tag, "_hold"}, work_out, ref_compress(blk, hv));
    endtask

    initial begin
        int lat, lat2, first, dones;
        bit ok;

        repeat (3) tick();
        check("reset_busy", 256'(busy), 256'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 256'(busy), 256'd0);
        check("idle_done", 256'(done), 256'd0);
        check("idle_work", work_out, 256'd0);

        run_and_check("abc", AbcBlk, HInit);
        check("abc_digest", add_words(work_out, HInit), AbcSum);
        run_and_check("empty", EmptyBlk, HInit);
        check("empty_digest", add_words(work_out, HInit), EmptySum);

        // A second start mid-block must be ignored.
        launch(AbcBlk, HInit);
        repeat (10) tick();
        block_in = EmptyBlk;
        h_in     = HInit;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        first = -1;
        dones = 0;
        for (int n = 12; n <= 160; n++) begin
            tick();
            if (done) begin
                dones++;
                if (first < 0) first = n;
            end
        end
        check("ignore_latency", 256'(first), 256'd64);
        check("ignore_done_count", 256'(dones), 256'd1);
        check("ignore_digest", add_words(work_out, HInit), AbcSum);
        check("ignore_idle", 256'(busy), 256'd0);

        // Reset in the middle of a block aborts it and clears the result.
        launch(EmptyBlk, HInit);
        repeat (30) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 256'(busy), 256'd0);
        check("abort_done", 256'(done), 256'd0);
        check("abort_work", work_out, 256'd0);
        dones = 0;
        for (int n = 0; n < 70; n++) begin
            tick();
            if (done || busy) dones++;
        end
        check("abort_quiet", 256'(dones), 256'd0);
        run_and_check("abc_after_abort", AbcBlk, HInit);
        check("abc_after_abort_digest", add_words(work_out, HInit), AbcSum);

        // Back-to-back: new start presented in the done cycle.
        launch(AbcBlk, HInit);
        wait_done(lat, ok);
        check("b2b_first_latency", 256'(lat), 256'd64);
        check("b2b_first_digest", add_words(work_out, HInit), AbcSum);
        block_in = EmptyBlk;
        h_in     = HInit;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("b2b_done_fall", 256'(done), 256'd0);
        check("b2b_busy", 256'(busy), 256'd1);
        check("b2b_hold", add_words(work_out, HInit), AbcSum);
        wait_done(lat2, ok);
        check("b2b_spacing", 256'(lat2 + 1), 256'd65);
        check("b2b_second_busy", 256'(ok), 256'd1);
        check("b2b_second_digest", add_words(work_out, HInit), EmptySum);
        tick();

        for (int i = 0; i < 4; i++) begin
            run_and_check($sformatf("rand%0d", i), rand_block(), rand_h());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
